// File: rtl/dcache_backing_mem_if.sv
// Block-transfer bus between the data cache (master) and its backing memory (slave).
// The cache holds read/write, address and writedata steady while busywait is high.
interface dcache_backing_mem_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/dcache_backing_mem.sv
// Slow block memory behind the data cache.
// Each access is latched on acceptance, spends LATENCY cycles in BUSY and completes
// on the last BUSY edge. A one-cycle DONE state follows so that a request still
// held while the cache reacts to busywait=0 cannot start a second access.
module dcache_backing_mem #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input logic                 clock,
    input logic                 reset,
    dcache_backing_mem_if.slave bus
);
    localparam int            CNT_W    = 4;
    localparam int            DEPTH    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] readdata_q;
    logic              busy_d;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic req;
    logic accept;
    logic access_fire;

    assign req         = bus.read | bus.write;
    assign accept      = (state_q == IDLE) && req;
    assign access_fire = (state_q == BUSY) && (cnt_q == '0);

    // State register and latency counter; only control state is reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Capture the request on acceptance; later changes on the bus are ignored.
    // A simultaneous read and write is treated as a write.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_write_q <= bus.write;
            addr_q     <= bus.address;
            wdata_q    <= bus.writedata;
        end
    end

    // Array write at the completing edge; a reset on that edge aborts it.
    always_ff @(posedge clock) begin
        if (!reset && access_fire && op_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Read result register: updated only by a completing read, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (access_fire && !op_write_q) begin
            readdata_q <= mem[addr_q];
        end
    end

    // Next-state logic and busywait; busywait rises in the request cycle itself.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busywait = busy_d;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_dcache_backing_mem.sv
// Directed and randomized bench for dcache_backing_mem with a flat array model.
module tb_dcache_backing_mem;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic clock;
    logic reset;

    dcache_backing_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dcache_backing_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: array contents and the last completed read value.
    logic [DATA_W-1:0] model_mem [0:DEPTH-1];
    logic [DATA_W-1:0] model_rd;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                         input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete access starting just after a rising edge. Counts busy cycles,
    // checks readdata holds during the access and is right in DONE, then returns
    // just after the DONE->IDLE edge with the request dropped.
    // perturb=1 changes address/write/writedata mid-access.
    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit perturb);
        int busy_cycles;
        bit done;
        busy_cycles   = 0;
        done          = 0;
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (bus.busywait) begin
                busy_cycles++;
                check({tag, " readdata hold"}, bus.readdata, model_rd);
                if (perturb && busy_cycles == 3) begin
                    bus.address   = a ^ 6'h30;
                    bus.write     = ~wr;
                    bus.writedata = $urandom;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end
        // Access finished at the edge into DONE.
        if (wr) model_mem[a] = d;
        else if (rd) model_rd = model_mem[a];
        check({tag, " busy cycles"}, 32'(busy_cycles), 32'(LATENCY + 1));
        check({tag, " readdata"}, bus.readdata, model_rd);
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        check({tag, " idle busywait"}, 32'(bus.busywait), 32'd0);
        check({tag, " idle readdata"}, bus.readdata, model_rd);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        bit rr, rw;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd      = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle_check("reset");

        // 1: read of an untouched block
        access("t1 read 00", 1, 0, 6'h00, 32'h0, 0);
        idle_check("t1");

        // 2: write then read back
        access("t2 write 2A", 0, 1, 6'h2A, 32'hDEADBEEF, 0);
        access("t2 read 2A", 1, 0, 6'h2A, 32'h0, 0);
        check("t2 readback", bus.readdata, 32'hDEADBEEF);

        // 3: write-back immediately followed by fill
        access("t3 write 05", 0, 1, 6'h05, 32'h11223344, 0);
        access("t3 read 25", 1, 0, 6'h25, 32'h0, 0);
        idle_check("t3");
        access("t3 read 05", 1, 0, 6'h05, 32'h0, 0);
        check("t3 mem05", bus.readdata, 32'h11223344);

        // 4: bus changes mid-access are ignored
        access("t4 write 10", 0, 1, 6'h10, 32'h0BADF00D, 0);
        access("t4 read 10", 1, 0, 6'h10, 32'h0, 1);
        check("t4 read 10 value", bus.readdata, 32'h0BADF00D);
        access("t4 read 20", 1, 0, 6'h20, 32'h0, 0);

        // 5: read and write together act as a write
        access("t5 rw 3F", 1, 1, 6'h3F, 32'hA5A5A5A5, 0);
        check("t5 readdata kept", bus.readdata, 32'h0);
        access("t5 read 3F", 1, 0, 6'h3F, 32'h0, 0);
        check("t5 mem3F", bus.readdata, 32'hA5A5A5A5);

        // 6: reset in the third BUSY cycle aborts the write
        bus.write     = 1'b1;
        bus.address   = 6'h3F;
        bus.writedata = 32'hCAFEF00D;
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b1;
        bus.write = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        model_rd = '0;
        @(negedge clock);
        check("t6 busywait after reset", 32'(bus.busywait), 32'd0);
        check("t6 readdata after reset", bus.readdata, 32'h0);
        @(posedge clock);
        #1;
        access("t6 read 3F", 1, 0, 6'h3F, 32'h0, 0);
        check("t6 old value", bus.readdata, 32'hA5A5A5A5);

        // Randomized mix of reads and writes against the model
        for (int n = 0; n < 30; n++) begin
            ra   = 6'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 6'h30 : 6'h00);
            rdat = $urandom;
            rr   = 1'($urandom);
            rw   = 1'($urandom);
            if (!rr && !rw) rr = 1'b1;
            access("rand", rr, rw, ra, rdat, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
